// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer-compare helpers for the sync_fifo slice.
// Pointers carry one extra wrap bit above the memory index bits.
package sync_fifo_pkg;

   localparam int DATA_WIDTH_DEF = 6;
   localparam int ADDR_WIDTH_DEF = 4;

   // Both pointers equal, wrap bit included: nothing stored.
   function automatic logic ptr_empty(
      input logic [31:0] wr,
      input logic [31:0] rd
   );
      return wr == rd;
   endfunction

   // Same slot but opposite lap: every slot holds live data.
   function automatic logic ptr_full(
      input logic [31:0] wr,
      input logic [31:0] rd,
      input logic [4:0]  aw
   );
      logic [31:0] mask;
      mask = (32'd1 << aw) - 32'd1;
      return (wr[aw] != rd[aw]) && ((wr & mask) == (rd & mask));
   endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle for sync_fifo.
// The master drives requests; the slave (the FIFO) returns data and status.
interface sync_fifo_if #(
   parameter int DATA_WIDTH = 6
);

   logic [DATA_WIDTH-1:0] data_in;
   logic                  write_enable;
   logic                  read_enable;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  fifo_full;
   logic                  fifo_empty;

   modport master (
      output data_in,
      output write_enable,
      output read_enable,
      input  data_out,
      input  fifo_full,
      input  fifo_empty
   );

   modport slave (
      input  data_in,
      input  write_enable,
      input  read_enable,
      output data_out,
      output fifo_full,
      output fifo_empty
   );

endinterface

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
// Only the read register is reset; the array keeps whatever it held.
module sync_fifo_mem #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] ram [DEPTH];

   // Store the incoming word on an accepted write.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         ram[wr_addr] <= wr_data;
      end
   end

   // Registered read; holds its value when no read is accepted.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= ram[rd_addr];
      end
   end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer and flag control around sync_fifo_mem.
// Reset input is active-high despite its legacy name.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input logic       clk,
   input logic       rst_n,
   sync_fifo_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [ADDR_WIDTH:0] wr_ptr;
   logic [ADDR_WIDTH:0] rd_ptr;
   logic                full;
   logic                empty;
   logic                wr_accept;
   logic                rd_accept;

   // Flags come only from registered pointers so they never glitch.
   always_comb begin
      empty = ptr_empty(32'(wr_ptr), 32'(rd_ptr));
      full  = ptr_full(32'(wr_ptr), 32'(rd_ptr), 5'(ADDR_WIDTH));
   end

   // Requests are dropped when they would overflow or underflow.
   always_comb begin
      wr_accept = bus.write_enable & ~full;
      rd_accept = bus.read_enable & ~empty;
   end

   // Write pointer advances once per stored word, wrapping naturally.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         wr_ptr <= '0;
      end else if (wr_accept) begin
         wr_ptr <= wr_ptr + 1'b1;
      end
   end

   // Read pointer advances once per delivered word.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rd_ptr <= '0;
      end else if (rd_accept) begin
         rd_ptr <= rd_ptr + 1'b1;
      end
   end

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_accept),
      .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
      .wr_data (bus.data_in),
      .rd_en   (rd_accept),
      .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
      .rd_data (bus.data_out)
   );

   assign bus.fifo_full  = full;
   assign bus.fifo_empty = empty;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: driver predicts, monitor compares.
// Directed fill, drain, wrap, concurrent and corner-case sequences.
module tb_sync_fifo;

   localparam int DW    = 6;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic clk;
   logic rst_n;

   sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

   sync_fifo #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests;
   int fails;

   logic [DW-1:0] mq [$];
   logic [DW-1:0] rd_q [$];
   logic [DW-1:0] last_out;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: after each edge, any predicted read result must be on data_out.
   always @(posedge clk) begin
      #1;
      if (rd_q.size() > 0) begin
         logic [DW-1:0] e;
         e = rd_q.pop_front();
         chk("rd_data", int'(bus.data_out), int'(e));
      end
   end

   // One cycle: check state left by the previous edge, then drive and predict.
   task automatic step(input logic we, input logic re, input logic [DW-1:0] d);
      bit wa;
      bit ra;
      @(negedge clk);
      chk("empty", int'(bus.fifo_empty), int'(mq.size() == 0));
      chk("full", int'(bus.fifo_full), int'(mq.size() == DEPTH));
      chk("hold", int'(bus.data_out), int'(last_out));
      bus.write_enable = we;
      bus.read_enable  = re;
      bus.data_in      = d;
      wa = we && (mq.size() < DEPTH);
      ra = re && (mq.size() > 0);
      if (ra) begin
         last_out = mq.pop_front();
         rd_q.push_back(last_out);
      end
      if (wa) mq.push_back(d);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      last_out = '0;
      bus.write_enable = 1'b0;
      bus.read_enable  = 1'b0;
      bus.data_in      = '0;

      // Reset held for 10 cycles
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("rst_empty", int'(bus.fifo_empty), 1);
      chk("rst_full", int'(bus.fifo_full), 0);
      chk("rst_dout", int'(bus.data_out), 0);
      rst_n = 1'b0;

      // Async reset mid-operation, no clock edge
      step(1, 0, 6'd5);
      step(1, 0, 6'd6);
      step(1, 0, 6'd7);
      step(0, 1, 6'd0);
      step(0, 0, 6'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("async_empty", int'(bus.fifo_empty), 1);
      chk("async_full", int'(bus.fifo_full), 0);
      chk("async_dout", int'(bus.data_out), 0);
      mq.delete();
      rd_q.delete();
      last_out = '0;
      @(negedge clk);
      rst_n = 1'b0;

      // Fill 0..15, then overflow write of 63
      for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(i));
      step(1, 0, 6'd63);

      // Drain 16 plus one underflow read
      for (int i = 0; i <= DEPTH; i++) step(0, 1, 6'd0);

      // Wrap across pointer boundary
      for (int i = 0; i < 10; i++) step(1, 0, DW'(20 + i));
      for (int i = 0; i < 10; i++) step(0, 1, 6'd0);
      for (int i = 0; i < 12; i++) step(1, 0, DW'(1 + 3 * i));
      for (int i = 0; i < 12; i++) step(0, 1, 6'd0);

      // Concurrent read/write at occupancy 5
      for (int i = 0; i < 5; i++) step(1, 0, DW'(50 + i));
      for (int i = 0; i < 20; i++) step(1, 1, DW'(30 + i));
      for (int i = 0; i < 5; i++) step(0, 1, 6'd0);

      // Empty with both enables: only the write lands
      step(1, 1, 6'd33);
      for (int i = 0; i < DEPTH - 1; i++) step(1, 0, DW'(10 + i));
      // Full with both enables: only the read lands
      step(1, 1, 6'd62);
      for (int i = 0; i < DEPTH; i++) step(0, 1, 6'd0);

      step(0, 0, 6'd0);
      step(0, 0, 6'd0);
      @(negedge clk);
      chk("final_rdq", rd_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
